cia_serial_peer: RTL and testbench
==================================

Name: cia_serial_peer

Overview:
- Byte-level serial transceiver for the far end of a CIA-style SP/CNT serial link, e.g. a fast-serial drive or a keyboard MCU model talking to the 6526/8520 serial port.
- Transmit: drives CNT as the shift clock and SP as data, MSB first, 8 bits per byte; the CIA samples SP on CNT rising edges.
- Receive: samples SP on CNT rising edges driven by the CIA in output mode and assembles bytes.
- All pins follow open-collector semantics: idle level 1, combined externally with AND.

Parameters:
RX_TIMEOUT, 255, ce ticks without a CNT rising edge, while a receive is partial, before the partial byte is discarded (1..65535).

Ports:
clk  input  1  system clock.
res_n  input  1  synchronous active-low reset.
ce  input  1  bit-timing clock enable, one clk wide (phi2-rate strobe).
half_period  input  8  ce ticks per CNT phase; value 0 is treated as 1.
tx_data  input  8  byte to transmit.
tx_valid  input  1  transmit request.
tx_ready  output  1  block accepts tx_data this clk.
tx_done  output  1  one-clk pulse when a byte has finished, including the trailing gap.
rx_data  output  8  last received byte.
rx_valid  output  1  one-clk pulse; rx_data is updated in the same clk.
rx_err  output  1  one-clk pulse when a partial byte is discarded on timeout.
busy  output  1  transmit in progress, or receive bit count nonzero.
cnt_in  input  1  CNT line level.
cnt_out  output  1  CNT drive; 1 = released.
sp_in  input  1  SP line level.
sp_out  output  1  SP drive; 1 = released.

Behaviour:
Reset
- When res_n=0 at a clk edge, all state returns to idle in that clk.
- Outputs after reset: cnt_out=1, sp_out=1, tx_ready=0 during reset, tx_done=0, rx_valid=0, rx_err=0, rx_data=0x00, busy=0.
- Internal: bit counters=0, cnt_prev=1.
- Reset mid-byte aborts the byte silently: no tx_done, no rx_valid.

Transmit state machine: states IDLE, TX_LOW, TX_HIGH, TX_GAP. Define hp = max(half_period,1), sampled when a phase timer is loaded.
- tx_ready = (state==IDLE) & (rx_bits==0) & res_n. It is combinational and not gated by ce.
- tx_valid & tx_ready at a clk edge:
  - shift ← tx_data, bit ← 0, timer ← hp-1, state ← TX_LOW;
  - cnt_out ← 0 and sp_out ← tx_data[7] in the same clk.
- Timer: decrements only on ce. A phase ends on the ce where timer==0, so each phase lasts exactly hp ce ticks.
- TX_LOW end: cnt_out ← 1, reload timer, state ← TX_HIGH.
- TX_HIGH end:
  - if bit==7: sp_out ← 1, reload timer, state ← TX_GAP;
  - otherwise: bit++, shift <<= 1, sp_out ← next bit, cnt_out ← 0, reload timer, state ← TX_LOW.
- TX_GAP end: state ← IDLE, tx_done pulses in that clk.
- Total byte time: 17*hp ce ticks. SP is stable across each CNT rising edge.
- tx_valid held continuously produces back-to-back bytes, each separated by one gap.

Receive
- Active only while state==IDLE, so own CNT edges are ignored.
- cnt_prev ← cnt_in on every ce.
- On ce with cnt_in & ~cnt_prev: rx_shift ← {rx_shift[6:0], sp_in}, rx_bits++, idle counter cleared.
- On the 8th edge: rx_data ← {rx_shift[6:0], sp_in}, rx_valid pulses in the same clk, rx_bits ← 0.
- There is no consumer handshake; a new byte overwrites rx_data.
- Timeout: while rx_bits≠0, the idle counter increments on each ce without a rising edge. On reaching RX_TIMEOUT: rx_bits ← 0, rx_err pulses, rx_shift is retained but irrelevant.
- Collision: a pending tx_valid waits (tx_ready=0) until the receive completes or times out.
- A rising edge and the timeout threshold on the same ce: the edge wins, and the counter clears.
- busy = (state≠IDLE) | (rx_bits≠0).

Test Plan:
- half_period=2, transmit 0xA5.
  - At CNT rising edges sp_out = 1,0,1,0,0,1,0,1.
  - CNT low/high 2 ce each; tx_done pulses 34 ce after acceptance; cnt_out=sp_out=1 afterwards.
- Bench drives 8 CNT pulses (low 3 ce, high 3 ce) with SP bits of 0x3C MSB first.
  - rx_valid pulses once, rx_data=0x3C, busy returns to 0.
- RX_TIMEOUT=16: drive 3 bits, then hold CNT high for 16 ce.
  - rx_err pulses and rx_bits=0.
  - A following full byte 0x81 is received correctly with no rx_err.
- Drive 3 bits, then assert tx_valid with 0x55.
  - tx_ready stays 0 and cnt_out stays 1 until the 8th edge (rx_valid with the driven byte).
  - The transmit then starts in the following clk.
- half_period=0, transmit 0xFF.
  - Each phase lasts 1 ce; tx_done 17 ce after acceptance.
- Reset asserted mid-transmit, during bit 4 of 0xF0.
  - cnt_out=sp_out=1 in the next clk, no tx_done, tx_ready=1 after reset release.
  - A subsequent transmit of 0x0F is bit-correct.

Source files
------------

// File: rtl/cia_serial_peer.sv
`default_nettype none
// ============================================================================
// Module      : cia_serial_peer
// Description : Far-end byte transceiver for a CIA-style SP/CNT serial link.
//               Transmits MSB first by driving CNT as shift clock and SP as
//               data; receives by sampling SP on CNT rising edges driven by
//               the CIA. Open-collector pins, 1 = released.
// Revision    : 1.0 - initial release
// ============================================================================
module cia_serial_peer #(
    parameter int RX_TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       ce,
    input  logic [7:0] half_period,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       busy,
    input  logic       cnt_in,
    output logic       cnt_out,
    input  logic       sp_in,
    output logic       sp_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TX_LOW  = 2'd1,
        TX_HIGH = 2'd2,
        TX_GAP  = 2'd3
    } state_t;

    localparam logic [16:0] C_RX_TIMEOUT = 17'(RX_TIMEOUT);

    state_t      r_state,    w_state;
    logic [7:0]  r_timer,    w_timer;
    logic [2:0]  r_bit,      w_bit;
    logic [7:0]  r_shift,    w_shift;
    logic        r_cnt_out,  w_cnt_out;
    logic        r_sp_out,   w_sp_out;
    logic        r_tx_done,  w_tx_done;
    logic [7:0]  r_rx_shift, w_rx_shift;
    logic [2:0]  r_rx_bits,  w_rx_bits;
    logic [7:0]  r_rx_data,  w_rx_data;
    logic        r_rx_valid, w_rx_valid;
    logic        r_rx_err,   w_rx_err;
    logic        r_cnt_prev, w_cnt_prev;
    logic [15:0] r_idle_cnt, w_idle_cnt;

    logic [7:0]  w_hp_m1;
    logic        w_rise;
    logic [16:0] w_idle_inc;

    // Phase reload value: a half_period of 0 behaves like 1.
    assign w_hp_m1    = (half_period == 8'd0) ? 8'd0 : half_period - 8'd1;
    assign w_rise     = ce & cnt_in & ~r_cnt_prev;
    assign w_idle_inc = {1'b0, r_idle_cnt} + 17'd1;

    assign tx_ready = (r_state == IDLE) & (r_rx_bits == 3'd0) & res_n;
    assign busy     = (r_state != IDLE) | (r_rx_bits != 3'd0);
    assign tx_done  = r_tx_done;
    assign rx_data  = r_rx_data;
    assign rx_valid = r_rx_valid;
    assign rx_err   = r_rx_err;
    assign cnt_out  = r_cnt_out;
    assign sp_out   = r_sp_out;

    // Next-state logic for transmit phases and the receive shifter.
    always_comb begin
        w_state    = r_state;
        w_timer    = r_timer;
        w_bit      = r_bit;
        w_shift    = r_shift;
        w_cnt_out  = r_cnt_out;
        w_sp_out   = r_sp_out;
        w_tx_done  = 1'b0;
        w_rx_shift = r_rx_shift;
        w_rx_bits  = r_rx_bits;
        w_rx_data  = r_rx_data;
        w_rx_valid = 1'b0;
        w_rx_err   = 1'b0;
        w_cnt_prev = r_cnt_prev;
        w_idle_cnt = r_idle_cnt;

        if (ce) begin
            w_cnt_prev = cnt_in;
        end

        case (r_state)
            IDLE: begin
                if (tx_valid && tx_ready) begin
                    w_shift   = tx_data;
                    w_bit     = 3'd0;
                    w_timer   = w_hp_m1;
                    w_state   = TX_LOW;
                    w_cnt_out = 1'b0;
                    w_sp_out  = tx_data[7];
                end
                // Receive runs only in IDLE so our own CNT edges are ignored.
                if (ce) begin
                    if (w_rise) begin
                        w_rx_shift = {r_rx_shift[6:0], sp_in};
                        w_idle_cnt = 16'd0;
                        if (r_rx_bits == 3'd7) begin
                            w_rx_data  = {r_rx_shift[6:0], sp_in};
                            w_rx_valid = 1'b1;
                            w_rx_bits  = 3'd0;
                        end else begin
                            w_rx_bits = r_rx_bits + 3'd1;
                        end
                    end else if (r_rx_bits != 3'd0) begin
                        if (w_idle_inc >= C_RX_TIMEOUT) begin
                            w_rx_bits  = 3'd0;
                            w_rx_err   = 1'b1;
                            w_idle_cnt = 16'd0;
                        end else begin
                            w_idle_cnt = w_idle_inc[15:0];
                        end
                    end
                end
            end

            TX_LOW: begin
                if (ce) begin
                    if (r_timer == 8'd0) begin
                        w_cnt_out = 1'b1;
                        w_timer   = w_hp_m1;
                        w_state   = TX_HIGH;
                    end else begin
                        w_timer = r_timer - 8'd1;
                    end
                end
            end

            TX_HIGH: begin
                if (ce) begin
                    if (r_timer == 8'd0) begin
                        w_timer = w_hp_m1;
                        if (r_bit == 3'd7) begin
                            w_sp_out = 1'b1;
                            w_state  = TX_GAP;
                        end else begin
                            w_bit     = r_bit + 3'd1;
                            w_shift   = {r_shift[6:0], 1'b0};
                            w_sp_out  = r_shift[6];
                            w_cnt_out = 1'b0;
                            w_state   = TX_LOW;
                        end
                    end else begin
                        w_timer = r_timer - 8'd1;
                    end
                end
            end

            TX_GAP: begin
                if (ce) begin
                    if (r_timer == 8'd0) begin
                        w_state   = IDLE;
                        w_tx_done = 1'b1;
                    end else begin
                        w_timer = r_timer - 8'd1;
                    end
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State register; reset abandons any byte in flight without pulses.
    always_ff @(posedge clk) begin
        if (!res_n) begin
            r_state    <= IDLE;
            r_timer    <= 8'd0;
            r_bit      <= 3'd0;
            r_shift    <= 8'd0;
            r_cnt_out  <= 1'b1;
            r_sp_out   <= 1'b1;
            r_tx_done  <= 1'b0;
            r_rx_shift <= 8'd0;
            r_rx_bits  <= 3'd0;
            r_rx_data  <= 8'd0;
            r_rx_valid <= 1'b0;
            r_rx_err   <= 1'b0;
            r_cnt_prev <= 1'b1;
            r_idle_cnt <= 16'd0;
        end else begin
            r_state    <= w_state;
            r_timer    <= w_timer;
            r_bit      <= w_bit;
            r_shift    <= w_shift;
            r_cnt_out  <= w_cnt_out;
            r_sp_out   <= w_sp_out;
            r_tx_done  <= w_tx_done;
            r_rx_shift <= w_rx_shift;
            r_rx_bits  <= w_rx_bits;
            r_rx_data  <= w_rx_data;
            r_rx_valid <= w_rx_valid;
            r_rx_err   <= w_rx_err;
            r_cnt_prev <= w_cnt_prev;
            r_idle_cnt <= w_idle_cnt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cia_serial_peer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cia_serial_peer
// Description : Self-checking bench for cia_serial_peer: directed and random
//               transmit/receive bytes, timeout, collision and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cia_serial_peer;

    localparam int RX_TO = 16;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       ce = 1'b0;
    logic [7:0] half_period = 8'd2;
    logic [7:0] tx_data = 8'd0;
    logic       tx_valid = 1'b0;
    logic       cnt_drv = 1'b1;
    logic       sp_drv = 1'b1;
    logic       tx_ready, tx_done, rx_valid, rx_err, busy, cnt_out, sp_out;
    logic [7:0] rx_data;
    logic       cnt_in, sp_in;

    // Open-collector lines: wired AND of both ends.
    assign cnt_in = cnt_out & cnt_drv;
    assign sp_in  = sp_out & sp_drv;

    cia_serial_peer #(.RX_TIMEOUT(RX_TO)) dut (
        .clk(clk), .res_n(res_n), .ce(ce), .half_period(half_period),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_done(tx_done), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_err(rx_err), .busy(busy), .cnt_in(cnt_in), .cnt_out(cnt_out),
        .sp_in(sp_in), .sp_out(sp_out)
    );

    always #5 clk = ~clk;

    // ce strobe: one clk high out of every three.
    initial begin
        forever begin
            repeat (2) @(negedge clk);
            ce = 1'b1;
            @(negedge clk);
            ce = 1'b0;
        end
    end

    // Line observer: counts ce ticks, CNT low phase lengths, SP at CNT rise.
    int         ce_total = 0;
    int         acc_ce = 0;
    int         done_ce = 0;
    int         done_n = 0;
    int         rxv_n = 0;
    int         rxe_n = 0;
    int         n_rise = 0;
    int         low_run = 0;
    int         low_bad = 0;
    logic       last_cnt = 1'b1;
    logic [7:0] seen_byte = 8'd0;

    always @(posedge clk) begin
        if (tx_done) begin
            done_ce <= ce_total - acc_ce;
            done_n  <= done_n + 1;
        end
        if (rx_valid) rxv_n <= rxv_n + 1;
        if (rx_err)   rxe_n <= rxe_n + 1;
        if (ce) ce_total <= ce_total + 1;
        if (tx_valid && tx_ready) acc_ce <= ce_total + (ce ? 1 : 0);
        if (ce && !cnt_out) low_run <= low_run + 1;
        if (cnt_out && !last_cnt) begin
            seen_byte <= {seen_byte[6:0], sp_out};
            n_rise    <= n_rise + 1;
            if (low_run != ((half_period == 8'd0) ? 1 : int'(half_period)))
                low_bad <= low_bad + 1;
            low_run <= 0;
        end
        last_cnt <= cnt_out;
    end

    int total = 0;
    int bad = 0;
    logic hold_chk = 1'b0;
    int hold_viol = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait n ce ticks; returns at the negedge after the last one.
    task automatic wait_ce(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (ce) k++;
            @(negedge clk);
            if (hold_chk && (tx_ready || !cnt_out)) hold_viol++;
        end
    endtask

    // One bench-driven bit: CNT low 3 ce with data, then high 3 ce.
    task automatic drive_bit(input logic b);
        sp_drv  = b;
        cnt_drv = 1'b0;
        wait_ce(3);
        cnt_drv = 1'b1;
        wait_ce(3);
    endtask

    task automatic wait_done(input string tag);
        int g = 0;
        while (!tx_done && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done_seen"}, 32'(tx_done), 32'd1);
        @(negedge clk);
    endtask

    // Transmit one byte and check it against the MSB-first line model.
    task automatic send(input string tag, input logic [7:0] b, input logic [7:0] hp);
        int base_rise, base_low, base_done, g, hpe;
        logic acc;
        hpe = (hp == 8'd0) ? 1 : int'(hp);
        half_period = hp;
        base_rise = n_rise; base_low = low_bad; base_done = done_n;
        tx_data = b;
        tx_valid = 1'b1;
        acc = 1'b0; g = 0;
        while (!acc && g < 3000) begin
            @(posedge clk);
            if (tx_ready) acc = 1'b1;
            g++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
        check({tag, "_accept"}, 32'(acc), 32'd1);
        wait_done(tag);
        check({tag, "_bits"}, 32'(seen_byte), 32'(b));
        check({tag, "_rises"}, 32'(n_rise - base_rise), 32'd8);
        check({tag, "_lowlen"}, 32'(low_bad - base_low), 32'd0);
        check({tag, "_bytetime"}, 32'(done_ce), 32'(17 * hpe));
        check({tag, "_donecnt"}, 32'(done_n - base_done), 32'd1);
        check({tag, "_idle_lines"}, {30'd0, cnt_out, sp_out}, 32'd3);
    endtask

    task automatic recv(input string tag, input logic [7:0] b);
        int base_v, base_e;
        base_v = rxv_n; base_e = rxe_n;
        for (int i = 7; i >= 0; i--) drive_bit(b[i]);
        sp_drv = 1'b1;
        @(negedge clk);
        check({tag, "_data"}, 32'(rx_data), 32'(b));
        check({tag, "_vcnt"}, 32'(rxv_n - base_v), 32'd1);
        check({tag, "_ecnt"}, 32'(rxe_n - base_e), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0] rb;
        int base, g;
        logic seen;

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_lines", {30'd0, cnt_out, sp_out}, 32'd3);
        check("rst_ready", 32'(tx_ready), 32'd0);
        check("rst_pulses", {29'd0, tx_done, rx_valid, rx_err}, 32'd0);
        check("rst_rxdata", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        res_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 32'(tx_ready), 32'd1);

        send("tx_a5", 8'hA5, 8'd2);
        recv("rx_3c", 8'h3C);

        // Partial byte timeout: 3 bits, then CNT held high.
        rb = 8'($urandom);
        base = rxe_n;
        drive_bit(rb[7]); drive_bit(rb[6]); drive_bit(rb[5]);
        sp_drv = 1'b1;
        wait_ce(RX_TO - 3);
        check("to_before_err", 32'(rx_err), 32'd0);
        check("to_before_busy", 32'(busy), 32'd1);
        wait_ce(1);
        check("to_err_pulse", 32'(rx_err), 32'd1);
        check("to_bits_clear", 32'(busy), 32'd0);
        @(negedge clk);
        check("to_ecnt", 32'(rxe_n - base), 32'd1);
        recv("rx_81", 8'h81);

        // Collision: pending transmit waits for the receive to finish.
        rb = 8'($urandom);
        drive_bit(rb[7]); drive_bit(rb[6]); drive_bit(rb[5]);
        half_period = 8'd2;
        tx_data = 8'h55;
        tx_valid = 1'b1;
        hold_viol = 0;
        hold_chk = 1'b1;
        for (int i = 4; i >= 1; i--) drive_bit(rb[i]);
        sp_drv = rb[0];
        cnt_drv = 1'b0;
        wait_ce(3);
        cnt_drv = 1'b1;
        seen = 1'b0; g = 0;
        while (!seen && g < 30) begin
            @(posedge clk);
            @(negedge clk);
            if (rx_valid) seen = 1'b1;
            else if (tx_ready || !cnt_out) hold_viol++;
            g++;
        end
        hold_chk = 1'b0;
        sp_drv = 1'b1;
        check("coll_hold", 32'(hold_viol), 32'd0);
        check("coll_rxv", 32'(seen), 32'd1);
        check("coll_rxdata", 32'(rx_data), 32'(rb));
        check("coll_ready", 32'(tx_ready), 32'd1);
        @(negedge clk);
        tx_valid = 1'b0;
        check("coll_start", {30'd0, cnt_out, sp_out}, 32'd0);
        wait_done("coll");
        check("coll_bits", 32'(seen_byte), 32'h55);

        send("tx_ff_hp0", 8'hFF, 8'd0);

        // Reset during bit 4 of 0xF0.
        base = done_n;
        g = n_rise;
        half_period = 8'd2;
        tx_data = 8'hF0;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 2000 && !seen; k++) begin
            @(negedge clk);
            if ((n_rise - g) == 4 && !cnt_out) seen = 1'b1;
        end
        check("rst_mid_reached", 32'(seen), 32'd1);
        res_n = 1'b0;
        @(negedge clk);
        check("rst_mid_lines", {30'd0, cnt_out, sp_out}, 32'd3);
        check("rst_mid_ready", 32'(tx_ready), 32'd0);
        res_n = 1'b1;
        @(negedge clk);
        check("rst_mid_rel_ready", 32'(tx_ready), 32'd1);
        wait_ce(40);
        check("rst_mid_nodone", 32'(done_n - base), 32'd0);
        send("tx_0f", 8'h0F, 8'd2);

        // Random bytes in both directions.
        for (int i = 0; i < 3; i++) begin
            send("tx_rand", 8'($urandom), 8'($urandom_range(0, 4)));
            recv("rx_rand", 8'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
